// File: rtl/piso_10bits_4_stages.sv
// piso_10bits_4_stages: parallel-in, serial-out unloader for the D_CFIR datapath.
// Takes a frame of four words {D4,D3,D2,D1} in one cycle and emits them oldest
// first (D4, D3, D2, D1) through a valid/ready handshake. A one-frame shadow
// buffer lets the next frame arrive while the current one is still draining,
// so back-to-back frames come out with no bubble.
// Optional feature macro: PISO_LAST_EN adds the dout_last output, which marks
// the fourth word of each frame.
module piso_10bits_4_stages #(
    parameter int WIDTH  = 10,
    parameter int STAGES = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic [WIDTH-1:0] D4,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready
`ifdef PISO_LAST_EN
    ,
    output logic             dout_last
`endif
);

    localparam int FRAME_W = STAGES * WIDTH;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]         state_q,      state_d;
    logic [1:0]         cnt_q,        cnt_d;
    logic [FRAME_W-1:0] shift_q,      shift_d;
    logic [FRAME_W-1:0] shadow_q,     shadow_d;
    logic               shadowFull_q, shadowFull_d;

    logic               loadXfer;
    logic               outXfer;
    logic               lastXfer;
    logic [FRAME_W-1:0] frameIn;

    // Handshake decode and output view of the shift register head
    always_comb begin
        load_ready = !Reset && !shadowFull_q;
        dout_valid = (state_q == SHIFT);
        dout       = dout_valid ? shift_q[FRAME_W-1 -: WIDTH] : '0;
        loadXfer   = load_valid && load_ready;
        outXfer    = dout_valid && dout_ready;
        lastXfer   = outXfer && (cnt_q == 2'd3);
        frameIn    = {D4, D3, D2, D1};
    end

`ifdef PISO_LAST_EN
    // Flag the fourth word of the frame while it is on dout (stalled or not)
    always_comb begin
        dout_last = dout_valid && (cnt_q == 2'd3);
    end
`endif

    // Next-state logic: frame load, word advance, shadow fill/drain and bypass
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        shadow_d     = shadow_q;
        shadowFull_d = shadowFull_q;
        case (state_q)
            IDLE: begin
                if (loadXfer) begin
                    shift_d = frameIn;
                    cnt_d   = 2'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (outXfer) begin
                    shift_d = shift_q << WIDTH;
                    cnt_d   = cnt_q + 2'd1;
                end
                if (lastXfer) begin
                    if (shadowFull_q) begin
                        shift_d      = shadow_q;
                        shadowFull_d = 1'b0;
                    end else if (loadXfer) begin
                        shift_d = frameIn;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (loadXfer) begin
                    shadow_d     = frameIn;
                    shadowFull_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight and shadowed frame at once
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            shift_q      <= '0;
            shadow_q     <= '0;
            shadowFull_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            shadow_q     <= shadow_d;
            shadowFull_q <= shadowFull_d;
        end
    end

endmodule
